// File: rtl/lc3_decode_pkg.sv
// rtl/lc3_decode_pkg.sv - shared opcode, control-field and bubble definitions for the LC-3 decode stage
//
// Purpose: opcode enum, W_Control codes, E_control field constants, the
//          decoded-control bundle type and the bubble constant.
// Ports:   none (package).
package lc3_decode_pkg;

  localparam int DW = 16;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  // Writeback source select.
  localparam logic [1:0] W_ALU = 2'd0;
  localparam logic [1:0] W_MEM = 2'd1;
  localparam logic [1:0] W_PC  = 2'd2;

  // E_control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_NOT = 2'd2;

  localparam logic [1:0] PCSEL1_OFF11 = 2'd0;
  localparam logic [1:0] PCSEL1_OFF9  = 2'd1;
  localparam logic [1:0] PCSEL1_OFF6  = 2'd2;
  localparam logic [1:0] PCSEL1_ZERO  = 2'd3;

  // pcselect2: 1 = npc is the address base, 0 = VSR1 is the base.
  localparam logic PCSEL2_NPC  = 1'b1;
  localparam logic PCSEL2_VSR1 = 1'b0;

  typedef struct packed {
    logic [5:0] e_control;
    logic [1:0] w_control;
    logic       mem_control;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [5:0] pack_e(input logic [1:0] alu, input logic [1:0] pcsel1,
                                        input logic pcsel2, input logic op2sel);
    return {alu, pcsel1, pcsel2, op2sel};
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// rtl/lc3_decode_ctrl.sv - combinational opcode to control-field table
//
// Purpose: maps the opcode (and imm bit) of the fetched word to the execute,
//          writeback and memory control fields plus an illegal-opcode flag.
// Ports:   opcode    in  [3:0]  instr[15:12]
//          imm_bit   in         instr[5]; selects immediate for ADD/AND
//          ctrl      out ctrl_t decoded control bundle
module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_bit,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode_e'(opcode))
      OP_ADD: ctrl.e_control = pack_e(ALU_ADD, PCSEL1_OFF11, PCSEL2_VSR1, ~imm_bit);
      OP_AND: ctrl.e_control = pack_e(ALU_AND, PCSEL1_OFF11, PCSEL2_VSR1, ~imm_bit);
      OP_NOT: ctrl.e_control = pack_e(ALU_NOT, PCSEL1_OFF11, PCSEL2_VSR1, 1'b0);
      OP_BR, OP_ST, OP_STI:
        ctrl.e_control = pack_e(ALU_ADD, PCSEL1_OFF9, PCSEL2_NPC, 1'b0);
      OP_LD, OP_LDI: begin
        ctrl.e_control = pack_e(ALU_ADD, PCSEL1_OFF9, PCSEL2_NPC, 1'b0);
        ctrl.w_control = W_MEM;
      end
      OP_LEA: begin
        ctrl.e_control = pack_e(ALU_ADD, PCSEL1_OFF9, PCSEL2_NPC, 1'b0);
        ctrl.w_control = W_PC;
      end
      OP_JMP: ctrl.e_control = pack_e(ALU_ADD, PCSEL1_ZERO, PCSEL2_VSR1, 1'b0);
      OP_STR: ctrl.e_control = pack_e(ALU_ADD, PCSEL1_OFF6, PCSEL2_VSR1, 1'b0);
      OP_LDR: begin
        ctrl.e_control = pack_e(ALU_ADD, PCSEL1_OFF6, PCSEL2_VSR1, 1'b0);
        ctrl.w_control = W_MEM;
      end
      // RTI, reserved, TRAP and JSR are not handled by this pipeline.
      default: ctrl.illegal = 1'b1;
    endcase
    // Indirect access flag rides on top of the address-mode decode above.
    if (opcode == OP_LDI || opcode == OP_STI) begin
      ctrl.mem_control = 1'b1;
    end
  end

endmodule

// File: rtl/lc3_decode_stage.sv
// rtl/lc3_decode_stage.sv - LC-3 decode pipeline register with control generation
//
// Purpose: registers the fetched instruction and next-PC and the decoded
//          control fields for the execute stage; supports stall, flush and
//          illegal-opcode flagging.
// Optional: define LC3_DECODE_ILLEGAL_CNT_EN to add a saturating 8-bit count
//           of accepted illegal opcodes on illegal_count.
// Ports:   clock, reset (async active-low)
//          enable_decode  in   advance; 0 holds all outputs
//          flush          in   load a bubble (overrides enable_decode)
//          instr_dout     in   [DW-1:0] fetched instruction
//          npc_in         in   [DW-1:0] PC+1 from fetch
//          IR, npc_out    out  [DW-1:0] registered instruction / next-PC
//          E_control      out  [5:0] {alu[1:0], pcsel1[1:0], pcsel2, op2sel}
//          W_Control      out  [1:0] writeback source
//          Mem_Control    out  indirect access
//          decode_valid   out  outputs hold a real instruction
//          illegal_op     out  registered instruction is unsupported
//          illegal_count  out  [7:0] (optional) saturating illegal count
module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int DW = lc3_decode_pkg::DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_decode,
  input  logic [DW-1:0] instr_dout,
  input  logic [DW-1:0] npc_in,
  input  logic          flush,
  output logic [DW-1:0] IR,
  output logic [DW-1:0] npc_out,
  output logic [5:0]    E_control,
  output logic [1:0]    W_Control,
  output logic          Mem_Control,
  output logic          decode_valid,
`ifdef LC3_DECODE_ILLEGAL_CNT_EN
  output logic [7:0]    illegal_count,
`endif
  output logic          illegal_op
);

  ctrl_t ctrl_next;

  lc3_decode_ctrl u_ctrl (
    .opcode  (instr_dout[15:12]),
    .imm_bit (instr_dout[5]),
    .ctrl    (ctrl_next)
  );

  logic accept;
  assign accept = enable_decode & ~flush;

  // A bubble is the reset image: IR = 0 decodes as BR nzp=000, a NOP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_control    <= CTRL_BUBBLE.e_control;
      W_Control    <= CTRL_BUBBLE.w_control;
      Mem_Control  <= CTRL_BUBBLE.mem_control;
      illegal_op   <= CTRL_BUBBLE.illegal;
      decode_valid <= 1'b0;
    end else if (flush) begin
      IR           <= '0;
      npc_out      <= '0;
      E_control    <= CTRL_BUBBLE.e_control;
      W_Control    <= CTRL_BUBBLE.w_control;
      Mem_Control  <= CTRL_BUBBLE.mem_control;
      illegal_op   <= CTRL_BUBBLE.illegal;
      decode_valid <= 1'b0;
    end else if (enable_decode) begin
      IR           <= instr_dout;
      npc_out      <= npc_in;
      E_control    <= ctrl_next.e_control;
      W_Control    <= ctrl_next.w_control;
      Mem_Control  <= ctrl_next.mem_control;
      illegal_op   <= ctrl_next.illegal;
      decode_valid <= 1'b1;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_count <= 8'h00;
    end else if (accept && ctrl_next.illegal && illegal_count != 8'hFF) begin
      illegal_count <= illegal_count + 8'h01;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: doc/lc3_decode_stage.md
Name: lc3_decode_stage

Overview:
- LC-3 pipeline decode stage; sits directly upstream of the execute stage.
- Registers the fetched instruction word and next-PC.
- Generates the execute, writeback and memory control fields the execute stage consumes: E_control, W_Control, Mem_Control.
- Supports stall (hold), flush (bubble insertion) and illegal-opcode flagging.

Parameters:
- DW, 16, instruction/PC datapath width (fixed at 16 for LC-3; exposed for package consistency only).

Ports:
- clock  input  1  stage clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets all state).
- enable_decode  input  1  stage advance; 0 = stall, hold all outputs.
- instr_dout  input  16  instruction word from fetch/imem.
- npc_in  input  16  PC+1 from fetch.
- flush  input  1  branch/jump taken; squash the instruction in decode.
- IR  output  16  registered instruction to execute.
- npc_out  output  16  registered next-PC to execute.
- E_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  0 = ALU result, 1 = memory data, 2 = PC/LEA result.
- Mem_Control  output  1  1 = indirect access (LDI/STI).
- decode_valid  output  1  registered outputs hold a real (non-bubble) instruction.
- illegal_op  output  1  registered; opcode unsupported (RTI 1000, reserved 1101, TRAP 1111, JSR 0100).

Behaviour:
- Reset (reset==0, async):
  - IR, npc_out = 16'h0000; E_control = 6'h00; W_Control = 2'b00.
  - Mem_Control, decode_valid, illegal_op = 0.
  - IR = 0 is BR with nzp=000, i.e. an architectural NOP.
- Latency: exactly 1 cycle; on the rising edge with enable_decode==1 && flush==0, outputs reflect instr_dout/npc_in of that cycle.
- Priority: flush > enable_decode.
  - flush==1: load bubble (reset values), decode_valid = 0, regardless of enable_decode.
- Stall: enable_decode==0 && flush==0 → all outputs hold, including decode_valid/illegal_op.
- Control decode, opcode = instr_dout[15:12], E_control shown as a 6-bit value:
  - ADD 0001 / AND 0101: alu = 00 / 01; op2select = ~instr[5]; pcselect fields 0.
    - ADD reg → 6'h01; ADD imm → 6'h00; AND reg → 6'h11; AND imm → 6'h10.
  - NOT 1001 → 6'h20; W = 0.
  - BR 0000 → 6'h06 (offset9, npc base).
  - JMP 1100 → 6'h0C (zero offset, VSR1 base).
  - LD 0010 / LEA 1110 / ST 0011 / LDI 1010 / STI 1011 → 6'h06.
  - LDR 0110 / STR 0111 → 6'h08 (offset6, VSR1 base).
  - W_Control = 1 for LD/LDR/LDI; 2 for LEA; 0 otherwise.
  - Mem_Control = 1 for LDI/STI only.
- Illegal opcode: controls = 0, IR and npc_out registered as-is, illegal_op = 1, decode_valid = 1.
- reset asserted mid-stall or mid-flush: reset wins immediately (async).
- Back-to-back flush cycles: remain bubble.
- flush while stalled: bubble is loaded.
- Control decode is purely a function of the current instr_dout; no multi-cycle state beyond the pipeline register and the optional counter.

Optional Feature:
- Macro: LC3_DECODE_ILLEGAL_CNT_EN.
- Defined:
  - Adds output illegal_count[7:0].
  - Increments on every accepted (enable_decode && !flush) illegal opcode.
  - Saturates at 8'hFF; reset to 0; held during stall.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package lc3_decode_pkg holds:
  - opcode enum (OP_BR … OP_TRAP);
  - W_Control codes (W_ALU = 0, W_MEM = 1, W_PC = 2);
  - E_control field constants (ALU_ADD/AND/NOT; PCSEL1_OFF11/OFF9/OFF6/ZERO);
  - bubble constant.
- Sub-module lc3_decode_ctrl: combinational opcode → {E_control, W_Control, Mem_Control, illegal} table, instantiated once ahead of the pipeline register.

Test Plan:
- Reset: drive reset=0 mid-run → all outputs 0 asynchronously. Release, enable=1, instr 16'h1283 (ADD R1,R2,R3), npc 16'h3001 → next edge: IR=16'h1283, npc_out=16'h3001, E_control=6'h01, W=0, decode_valid=1.
- Opcode sweep:
  - 16'h5025 (AND imm) → E_control 6'h10.
  - 16'h2005 (LD) → 6'h06, W=1, Mem=0.
  - 16'hA005 (LDI) → 6'h06, W=1, Mem=1.
  - 16'hE005 (LEA) → W=2.
  - 16'h6042 (LDR) → 6'h08, W=1.
  - 16'hC1C0 (JMP) → 6'h0C.
- Stall: accept 16'h1283, then enable=0 for 3 cycles with instr_dout changing → outputs unchanged; re-enable → new instr appears next edge.
- Flush priority: flush=1, enable=1, instr 16'h2005 → IR=0, E_control=0, decode_valid=0. Flush with enable=0 also yields a bubble.
- Illegal: instr 16'hD000 → illegal_op=1, controls 0, IR=16'hD000. With LC3_DECODE_ILLEGAL_CNT_EN, 300 accepted illegal instructions → illegal_count=8'hFF (saturated).
